uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_receiver.sv | 138 +++++++++++++
 tb/tb_uart_receiver.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: default frame geometry, one-hot receiver states and
// the start/stop bit levels used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned WORD_SIZE_DEF   = 8;
  localparam int unsigned SAMPLE_RATE_DEF = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'b001,
    STARTING  = 3'b010,
    RECEIVING = 3'b100
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so reset release never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;
  logic meta_d, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver with overrun (Error1) and framing (Error2) flags.
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on Serial_in.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned word_size   = WORD_SIZE_DEF,
  parameter int unsigned sample_rate = SAMPLE_RATE_DEF
) (
  input  logic                 Clock,
  input  logic                 reset_,
  input  logic                 Serial_in,
  input  logic                 read_not_ready_in,
  output logic [word_size-1:0] RCV_datareg,
  output logic                 read_not_ready_out,
  output logic                 Error1,
  output logic                 Error2
);

  localparam int unsigned SC_W = $clog2(sample_rate);
  localparam int unsigned BC_W = $clog2(word_size) + 1;
  localparam logic [SC_W-1:0] HALF_LAST   = SC_W'(sample_rate / 2 - 1);
  localparam logic [SC_W-1:0] SAMPLE_LAST = SC_W'(sample_rate - 1);
  localparam logic [BC_W-1:0] BITS_ALL    = BC_W'(word_size);

  logic rx;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clk   (Clock),
    .rst_n (reset_),
    .d     (Serial_in),
    .q     (rx)
  );
`else
  assign rx = Serial_in;
`endif

  rx_state_e             state_q, state_d;
  logic [SC_W-1:0]       sample_cnt_q, sample_cnt_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [word_size-1:0]  shft_q, shft_d;
  logic [word_size-1:0]  data_q, data_d;
  logic                  load_q, load_d;
  logic                  rnr_out_q, rnr_out_d;
  logic                  err1_q, err1_d;
  logic                  err2_q, err2_d;

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shft_d       = shft_q;
    data_d       = data_q;
    load_d       = 1'b0;
    err1_d       = 1'b0;
    err2_d       = 1'b0;
    // Data becomes visible on the stop-sample edge; the ready pulse trails by one cycle.
    rnr_out_d    = load_q;

    case (state_q)
      IDLE: begin
        sample_cnt_d = '0;
        bit_cnt_d    = '0;
        if (rx == START_BIT) begin
          sample_cnt_d = SC_W'(1);
          state_d      = STARTING;
        end
      end
      STARTING: begin
        if (rx != START_BIT) begin
          sample_cnt_d = '0;
          state_d      = IDLE;
        end else if (sample_cnt_q == HALF_LAST) begin
          sample_cnt_d = '0;
          state_d      = RECEIVING;
        end else begin
          sample_cnt_d = sample_cnt_q + 1'b1;
        end
      end
      RECEIVING: begin
        sample_cnt_d = sample_cnt_q + 1'b1;
        if (sample_cnt_q == SAMPLE_LAST) begin
          sample_cnt_d = '0;
          if (bit_cnt_q != BITS_ALL) begin
            shft_d    = {rx, shft_q[word_size-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            bit_cnt_d = '0;
            state_d   = IDLE;
            if (read_not_ready_in) begin
              err1_d = 1'b1;
            end else if (rx != STOP_BIT) begin
              err2_d = 1'b1;
            end else begin
              data_d = shft_q;
              load_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d      = IDLE;
        sample_cnt_d = '0;
        bit_cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge reset_) begin
    if (!reset_) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shft_q       <= '0;
      data_q       <= '0;
      load_q       <= 1'b0;
      rnr_out_q    <= 1'b0;
      err1_q       <= 1'b0;
      err2_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shft_q       <= shft_d;
      data_q       <= data_d;
      load_q       <= load_d;
      rnr_out_q    <= rnr_out_d;
      err1_q       <= err1_d;
      err2_q       <= err2_d;
    end
  end

  assign RCV_datareg        = data_q;
  assign read_not_ready_out = rnr_out_q;
  assign Error1             = err1_q;
  assign Error2             = err2_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at 8 data bits, 8 clocks/bit.
module tb_uart_receiver;

  localparam int unsigned WS = 8;
  localparam int unsigned SR = 8;

  logic          Clock = 1'b0;
  logic          reset_ = 1'b1;
  logic          Serial_in = 1'b1;
  logic          read_not_ready_in = 1'b0;
  logic [WS-1:0] RCV_datareg;
  logic          read_not_ready_out;
  logic          Error1;
  logic          Error2;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned rnr_total = 0;
  int unsigned e1_total  = 0;
  int unsigned e2_total  = 0;

  uart_receiver #(.word_size(WS), .sample_rate(SR)) dut (
    .Clock              (Clock),
    .reset_             (reset_),
    .Serial_in          (Serial_in),
    .read_not_ready_in  (read_not_ready_in),
    .RCV_datareg        (RCV_datareg),
    .read_not_ready_out (read_not_ready_out),
    .Error1             (Error1),
    .Error2             (Error2)
  );

  always #5 Clock = ~Clock;

  // Count cycles each pulse output is high; tasks compare deltas.
  always @(negedge Clock) begin
    if (read_not_ready_out === 1'b1) rnr_total <= rnr_total + 1;
    if (Error1 === 1'b1)             e1_total  <= e1_total + 1;
    if (Error2 === 1'b1)             e2_total  <= e2_total + 1;
  end

  task automatic drive_bit(input logic b, input int unsigned n);
    Serial_in = b;
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [WS-1:0] data, input logic stop_val,
                            input int unsigned stop_cycles);
    drive_bit(1'b0, SR);
    for (int unsigned i = 0; i < WS; i++) drive_bit(data[i], SR);
    drive_bit(stop_val, stop_cycles);
    Serial_in = 1'b1;
  endtask

  task automatic check_frame(input string name, input logic [WS-1:0] exp_data,
                             input int unsigned exp_rnr, input int unsigned exp_e1,
                             input int unsigned exp_e2, input int unsigned r0,
                             input int unsigned a0, input int unsigned b0);
    n_cmp++;
    if (RCV_datareg !== exp_data) begin
      n_bad++;
      $display("FAIL %s data: got %h expected %h", name, RCV_datareg, exp_data);
    end
    n_cmp++;
    if (rnr_total - r0 !== exp_rnr) begin
      n_bad++;
      $display("FAIL %s rnr_out cycles: got %0d expected %0d", name, rnr_total - r0, exp_rnr);
    end
    n_cmp++;
    if (e1_total - a0 !== exp_e1) begin
      n_bad++;
      $display("FAIL %s Error1 cycles: got %0d expected %0d", name, e1_total - a0, exp_e1);
    end
    n_cmp++;
    if (e2_total - b0 !== exp_e2) begin
      n_bad++;
      $display("FAIL %s Error2 cycles: got %0d expected %0d", name, e2_total - b0, exp_e2);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    n_cmp++;
    if (RCV_datareg !== '0) begin
      n_bad++;
      $display("FAIL %s data: got %h expected 00", name, RCV_datareg);
    end
    n_cmp++;
    if (read_not_ready_out !== 1'b0) begin
      n_bad++;
      $display("FAIL %s rnr_out: got %b expected 0", name, read_not_ready_out);
    end
    n_cmp++;
    if (Error1 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s Error1: got %b expected 0", name, Error1);
    end
    n_cmp++;
    if (Error2 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s Error2: got %b expected 0", name, Error2);
    end
  endtask

  task automatic test_reset();
    #1 reset_ = 1'b0;
    #1 check_zero_outputs("reset");
    repeat (3) @(negedge Clock);
    reset_ = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  task automatic test_good_frame();
    int unsigned r0 = rnr_total, a0 = e1_total, b0 = e2_total;
    send_frame(8'hA5, 1'b1, SR);
    repeat (12) @(negedge Clock);
    check_frame("frame_A5", 8'hA5, 1, 0, 0, r0, a0, b0);
  endtask

  task automatic test_false_start();
    int unsigned r0 = rnr_total, a0 = e1_total, b0 = e2_total;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 3 * SR * (WS + 2));
    check_frame("false_start", 8'hA5, 0, 0, 0, r0, a0, b0);
  endtask

  task automatic test_framing_error();
    int unsigned r0 = rnr_total, a0 = e1_total, b0 = e2_total;
    // Stop bit held low only across its sample point so no new frame starts.
    send_frame(8'h3C, 1'b0, SR / 2 + 2);
    repeat (2 * SR * (WS + 2)) @(negedge Clock);
    check_frame("framing_3C", 8'hA5, 0, 0, 1, r0, a0, b0);
  endtask

  task automatic test_overrun();
    int unsigned r0 = rnr_total, a0 = e1_total, b0 = e2_total;
    read_not_ready_in = 1'b1;
    send_frame(8'h5A, 1'b1, SR);
    repeat (12) @(negedge Clock);
    read_not_ready_in = 1'b0;
    check_frame("overrun_5A", 8'hA5, 0, 1, 0, r0, a0, b0);
  endtask

  task automatic test_back_to_back();
    int unsigned r0 = rnr_total, a0 = e1_total, b0 = e2_total;
    send_frame(8'h00, 1'b1, SR);
    send_frame(8'hFF, 1'b1, SR);
    repeat (12) @(negedge Clock);
    check_frame("b2b_00_FF", 8'hFF, 2, 0, 0, r0, a0, b0);
  endtask

  task automatic test_reset_mid_frame();
    logic [WS-1:0] d = 8'h6B;
    int unsigned r0 = rnr_total, a0 = e1_total, b0 = e2_total;
    drive_bit(1'b0, SR);
    for (int unsigned i = 0; i < 4; i++) drive_bit(d[i], SR);
    drive_bit(d[4], 3);
    reset_ = 1'b0;
    #1 check_zero_outputs("reset_mid");
    Serial_in = 1'b1;
    repeat (3) @(negedge Clock);
    reset_ = 1'b1;
    drive_bit(1'b1, SR);
    check_frame("reset_mid_quiet", 8'h00, 0, 0, 0, r0, a0, b0);
    r0 = rnr_total; a0 = e1_total; b0 = e2_total;
    send_frame(8'h81, 1'b1, SR);
    repeat (12) @(negedge Clock);
    check_frame("after_reset_81", 8'h81, 1, 0, 0, r0, a0, b0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_false_start();
    test_framing_error();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
